// File: rtl/fir_sym_mac.sv
// Time-multiplexed symmetric FIR: one shared pre-add/multiply/accumulate datapath
// serving NCH channels, with double-buffered runtime coefficients, rounding and saturation.
module fir_sym_mac #(
  parameter int DW    = 12,
  parameter int CW    = 13,
  parameter int TAPS  = 31,
  parameter int NCH   = 2,
  parameter int SHIFT = 11,
  localparam int H    = (TAPS + 1) / 2,
  localparam int AW   = $clog2(H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              f_s,
  input  logic [NCH*DW-1:0] din,
  input  logic              cf_we,
  input  logic [AW-1:0]     cf_addr,
  input  logic [CW-1:0]     cf_wdata,
  output logic [NCH*DW-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              sat,
  output logic              ovr
);

  localparam int TW   = $clog2(TAPS);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACCW = DW + 1 + CW + AW;
  localparam int PW   = DW + 1 + CW;
  localparam logic signed [CW-1:0] CF_UNITY = CW'(2 ** SHIFT);
  localparam logic signed [ACCW:0] RND      = (ACCW + 1)'(2 ** (SHIFT - 1));
  localparam logic signed [ACCW:0] R_MAX    = (ACCW + 1)'(2 ** (DW - 1) - 1);
  localparam logic signed [ACCW:0] R_MIN    = (ACCW + 1)'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;

  logic                   pl0, pl1;
  logic                   start_cond, start;
  logic signed [DW-1:0]   x [NCH][TAPS];
  logic signed [CW-1:0]   cf_sh  [H];
  logic signed [CW-1:0]   cf_act [H];
  logic [CHW-1:0]         ch;
  logic [AW-1:0]          k;
  logic signed [ACCW-1:0] acc, acc_nx;
  logic signed [DW-1:0]   hold [NCH];
  logic                   hold_sat [NCH];

  logic [TW-1:0]          ia, ib;
  logic signed [DW-1:0]   xa, xb;
  logic                   center;
  logic signed [DW:0]     pre;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW:0]   rnd, r;
  logic signed [DW-1:0]   fin;
  logic                   fin_sat, any_sat;
  logic [NCH*DW-1:0]      dout_nx;

  assign start_cond = pl0 & ~pl1 & en;
  assign start      = start_cond & (state == IDLE);
  assign busy       = (state != IDLE);
  assign dout_valid = (state == OUT);

  // Mirror taps x[k] and x[TAPS-1-k] share cf[k]; the centre tap is used alone.
  assign ia     = TW'(k);
  assign ib     = TW'(TAPS - 1) - ia;
  assign xa     = x[ch][ia];
  assign xb     = x[ch][ib];
  assign center = (k == AW'(H - 1));

  always_comb begin
    if (center) pre = (DW + 1)'(xa);
    else        pre = (DW + 1)'(xa) + (DW + 1)'(xb);
    prod   = pre * cf_act[k];
    acc_nx = acc + ACCW'(prod);
    rnd    = (ACCW + 1)'(acc_nx) + RND;
    r      = rnd >>> SHIFT;
    fin_sat = 1'b0;
    if (r > R_MAX) begin
      fin     = R_MAX[DW-1:0];
      fin_sat = 1'b1;
    end else if (r < R_MIN) begin
      fin     = R_MIN[DW-1:0];
      fin_sat = 1'b1;
    end else begin
      fin = r[DW-1:0];
    end
  end

  // The last channel's result bypasses its holding register so dout lands with OUT.
  always_comb begin
    dout_nx = '0;
    any_sat = fin_sat;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (c == NCH - 1) begin
        dout_nx[c*DW +: DW] = fin;
      end else begin
        dout_nx[c*DW +: DW] = hold[c];
        any_sat = any_sat | hold_sat[c];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (center && ch == CHW'(NCH - 1)) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pl0  <= 1'b0;
      pl1  <= 1'b0;
      ovr  <= 1'b0;
      sat  <= 1'b0;
      dout <= '0;
      acc  <= '0;
      ch   <= '0;
      k    <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        hold[c]     <= '0;
        hold_sat[c] <= 1'b0;
        for (int unsigned t = 0; t < TAPS; t++) x[c][t] <= '0;
      end
      for (int unsigned i = 0; i < H; i++) begin
        cf_sh[i]  <= (i == H - 1) ? CF_UNITY : '0;
        cf_act[i] <= (i == H - 1) ? CF_UNITY : '0;
      end
    end else begin
      pl0 <= f_s;
      pl1 <= pl0;
      if (start_cond && state != IDLE) ovr <= 1'b1;
      if (cf_we && {1'b0, cf_addr} < (AW + 1)'(H)) cf_sh[cf_addr] <= cf_wdata;

      if (start) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          x[c][0] <= din[c*DW +: DW];
          for (int unsigned t = 1; t < TAPS; t++) x[c][t] <= x[c][t-1];
        end
        cf_act <= cf_sh;
        acc    <= '0;
        ch     <= '0;
        k      <= '0;
      end else if (state == MAC) begin
        if (center) begin
          hold[ch]     <= fin;
          hold_sat[ch] <= fin_sat;
          acc          <= '0;
          k            <= '0;
          ch           <= ch + CHW'(1);
          if (ch == CHW'(NCH - 1)) begin
            dout <= dout_nx;
            sat  <= any_sat;
          end
        end else begin
          acc <= acc_nx;
          k   <= k + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_sym_mac.sv
// Scoreboard bench for fir_sym_mac: the driver queues hand-computed outputs per strobe,
// the monitor pops and compares on every dout_valid, including the exact latency.
module tb_fir_sym_mac;
  localparam int DW = 12, CW = 13, TAPS = 31, NCH = 2, SHIFT = 11;
  localparam int H = 16, AW = 4;

  logic              clk = 1'b0;
  logic              rst, en, f_s, cf_we;
  logic [NCH*DW-1:0] din;
  logic [AW-1:0]     cf_addr;
  logic [CW-1:0]     cf_wdata;
  logic [NCH*DW-1:0] dout;
  logic              dout_valid, busy, sat, ovr;

  fir_sym_mac #(.DW(DW), .CW(CW), .TAPS(TAPS), .NCH(NCH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .en(en), .f_s(f_s), .din(din),
    .cf_we(cf_we), .cf_addr(cf_addr), .cf_wdata(cf_wdata),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .sat(sat), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int e0;
    int e1;
    int es;
    int ecyc;
    bit chk;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every dout_valid must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dout_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("spurious_dout_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("latency", cyc, e.ecyc);
          if (e.chk) begin
            check("dout_ch0", int'($signed(dout[DW-1:0])), e.e0);
            check("dout_ch1", int'($signed(dout[2*DW-1:DW])), e.e1);
            check("sat", int'(sat), e.es);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_din(input int d0, input int d1);
    din[DW-1:0]      = DW'(d0);
    din[2*DW-1:DW]   = DW'(d1);
  endtask

  task automatic expect_out(input int e0, input int e1, input int es, input int ecyc, input bit chk);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.es = es; e.ecyc = ecyc; e.chk = chk;
    sbq.push_back(e);
  endtask

  // Raise f_s in cycle n; start condition is cycle n+1 (S), output at S+33.
  task automatic raise(input int d0, input int d1, output int n);
    set_din(d0, d1);
    f_s = 1'b1;
    n = cyc;
  endtask

  task automatic strobe(input int d0, input int d1, input bit chk, input int e0, input int e1, input int es);
    int n;
    raise(d0, d1, n);
    expect_out(e0, e1, es, n + 34, chk);
    tick(2);
    f_s = 1'b0;
    tick(38);
  endtask

  task automatic load_cf(input int a, input int v);
    cf_we = 1'b1;
    cf_addr = AW'(a);
    cf_wdata = CW'(v);
    tick(1);
    cf_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  int hpf [16] = '{-61, 60, 46, 38, 30, 19, 1, -23, -53, -88, -126, -162, -195, -221, -238, 1955};
  int hpf_imp [31] = '{-30, 29, 22, 19, 15, 9, 0, -11, -26, -43, -62, -79, -95, -108, -116, 955,
                       -116, -108, -95, -79, -62, -43, -26, -11, 0, 9, 15, 19, 22, 29, -30};

  initial begin
    int n;
    rst = 1'b0; en = 1'b1; f_s = 1'b0; cf_we = 1'b0;
    din = '0; cf_addr = '0; cf_wdata = '0;
    tick(3);
    check("rst_dout", int'(dout), 0);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_ovr", int'(ovr), 0);
    rst = 1'b1;
    tick(2);

    // Reset coefficients: unity centre tap, group delay 15 samples.
    raise(1000, -500, n);
    expect_out(0, 0, 0, n + 34, 1'b1);
    tick(1);
    check("busy_at_S", int'(busy), 0);
    tick(1);
    f_s = 1'b0;
    check("busy_at_S+1", int'(busy), 1);
    tick(32);
    check("busy_at_S+33", int'(busy), 1);
    tick(1);
    check("busy_at_S+34", int'(busy), 0);
    tick(5);
    for (int i = 2; i <= 15; i++) strobe(0, 0, 1'b1, 0, 0, 0);
    strobe(0, 0, 1'b1, 1000, -500, 0);
    strobe(0, 0, 1'b1, 0, 0, 0);

    // HPF set: impulse response, then DC steady state.
    do_reset();
    for (int i = 0; i < 16; i++) load_cf(i, hpf[i]);
    for (int i = 0; i < 31; i++) strobe((i == 0) ? 1000 : 0, 0, 1'b1, hpf_imp[i], 0, 0);
    for (int i = 0; i < 30; i++) strobe(1000, 0, 1'b0, 0, 0, 0);
    strobe(1000, 0, 1'b1, 4, 0, 0);

    // Saturation on either channel, then recovery.
    do_reset();
    load_cf(15, 4095);
    for (int i = 0; i < 15; i++) strobe(2047, 100, 1'b1, 0, 0, 0);
    strobe(2047, 100, 1'b1, 2047, 200, 1);
    for (int i = 0; i < 15; i++) strobe(100, -2048, 1'b1, 2047, 200, 1);
    strobe(100, -2048, 1'b1, 200, -2048, 1);
    for (int i = 0; i < 15; i++) strobe(100, 100, 1'b1, 200, -2048, 1);
    strobe(100, 100, 1'b1, 200, 200, 0);

    // Overrun and en=0: out = x0 + x1/2 shows which samples were shifted in.
    do_reset();
    load_cf(0, 2048);
    load_cf(1, 1024);
    load_cf(15, 0);
    check("ovr_before", int'(ovr), 0);
    raise(300, 0, n);
    expect_out(300, 0, 0, n + 34, 1'b1);
    tick(2);
    f_s = 1'b0;
    tick(8);
    set_din(700, 0);
    f_s = 1'b1;
    tick(2);
    f_s = 1'b0;
    tick(28);
    check("ovr_after", int'(ovr), 1);
    en = 1'b0;
    set_din(900, 0);
    f_s = 1'b1;
    tick(2);
    f_s = 1'b0;
    tick(2);
    en = 1'b1;
    tick(36);
    check("ovr_sticky", int'(ovr), 1);
    strobe(0, 0, 1'b1, 150, 0, 0);

    // Reset mid-computation: immediate clear, no output, power-up behaviour after.
    check("pre_rst_dout", int'($signed(dout[DW-1:0])), 150);
    raise(555, 0, n);
    tick(2);
    f_s = 1'b0;
    tick(9);
    rst = 1'b0;
    #1;
    check("abort_dout", int'(dout), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_dout_valid", int'(dout_valid), 0);
    check("abort_ovr", int'(ovr), 0);
    tick(3);
    rst = 1'b1;
    tick(40);
    strobe(555, 0, 1'b1, 0, 0, 0);

    // Coefficient write while busy lands only in the shadow bank.
    do_reset();
    load_cf(0, 2048);
    raise(400, 0, n);
    expect_out(400, 0, 0, n + 34, 1'b1);
    tick(2);
    f_s = 1'b0;
    tick(4);
    load_cf(0, 0);
    tick(33);
    strobe(600, 0, 1'b1, 0, 0, 0);

    for (int i = 0; i < 100 && sbq.size() != 0; i++) tick(1);
    check("queue_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
